// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int HDR_RW_BIT   = 0;
  localparam int HDR_ADDR_LSB = 1;
  localparam int HDR_ADDR_MSB = 7;

  function automatic logic hdr_match(input logic [7:0] hdr, input logic [6:0] dev);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] == dev;
  endfunction

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Host-side register port: write strobe plus a continuously-indexed read path.
interface i2c_target_regfile_if #(
  parameter int PTR_W = 4
);
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] rd_addr;
  logic [7:0]       rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser, FILT_LEN-sample glitch filter and edge strobes for one bus line.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILT_LEN) + 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          rise_q, fall_q;

  // Count consecutive samples that disagree with the filtered value; flip on the FILT_LEN-th.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = sync_q[1];
      else                            cnt_d  = cnt_q + CW'(1);
    end
  end

  // Idle bus is high, so reset to 1 to avoid a spurious edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target with an auto-incrementing register pointer and burst read/write.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h54,
  parameter int         NREGS    = 16,
  parameter int         PTR_W    = $clog2(NREGS),
  parameter int         FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_oe,
  output logic busy,
  output logic addr_hit,
  i2c_target_regfile_if.master reg_if
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start_evt, stop_evt;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk, .rst_n, .line_i(scl_in), .filt_o(scl_f), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk, .rst_n, .line_i(sda_in), .filt_o(sda_f), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_evt = sda_fall & scl_f;
  assign stop_evt  = sda_rise & scl_f;

  i2c_state_e       state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ph_q, ph_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             hit_q, hit_d;
  logic             wen_q, wen_d;
  logic [PTR_W-1:0] waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;

  logic [7:0]       rx_byte;
  logic [PTR_W-1:0] ptr_inc, ptr_mod;

  assign rx_byte = {shift_q[6:0], sda_f};
  assign ptr_inc = (ptr_q == PTR_W'(NREGS - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_mod = PTR_W'(32'(rx_byte) % 32'(NREGS));

  // ph_q marks that the ACK-slot rising edge has passed; the next fall ends the slot.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    ph_d     = ph_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    hit_d    = 1'b0;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (stop_evt) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_evt) begin
      state_d  = ST_ADDR;
      bitcnt_d = '0;
      oe_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
          shift_d  = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            ph_d = 1'b0;
            case (state_q)
              ST_ADDR: begin
                if (hdr_match(rx_byte, DEV_ADDR)) begin
                  hit_d   = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ST_ADDR_ACK;
                end else begin
                  state_d = ST_IDLE;
                end
              end
              ST_PTR: begin
                ptr_d   = ptr_mod;
                state_d = ST_PTR_ACK;
              end
              default: begin
                wen_d   = 1'b1;
                waddr_d = ptr_q;
                wdata_d = rx_byte;
                ptr_d   = ptr_inc;
                state_d = ST_WDATA_ACK;
              end
            endcase
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            ph_d = 1'b1;
          end else if (scl_fall) begin
            if (!ph_q) begin
              oe_d = ~ACK;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = '0;
              if (state_q == ST_ADDR_ACK && shift_q[HDR_RW_BIT]) begin
                shift_d = reg_if.rd_data;
                oe_d    = ~reg_if.rd_data[7];
                state_d = ST_RDATA;
              end else begin
                state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
        end
        // Rotate so the next outgoing bit is always in shift_q[6] at the falling edge.
        ST_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              ptr_d   = ptr_inc;
              ph_d    = 1'b0;
              state_d = ST_RACK;
            end
          end else if (scl_fall) begin
            shift_d = {shift_q[6:0], shift_q[7]};
            oe_d    = ~shift_q[6];
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (sda_f == NACK) state_d = ST_IDLE;
            else               ph_d    = 1'b1;
          end else if (scl_fall) begin
            if (!ph_q) begin
              oe_d = 1'b0;
            end else begin
              shift_d  = reg_if.rd_data;
              oe_d     = ~reg_if.rd_data[7];
              bitcnt_d = '0;
              state_d  = ST_RDATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      ph_q     <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      hit_q    <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      ph_q     <= ph_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      hit_q    <= hit_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign sda_oe         = oe_q;
  assign busy           = busy_q;
  assign addr_hit       = hit_q;
  assign reg_if.wr_en   = wen_q;
  assign reg_if.wr_addr = waddr_q;
  assign reg_if.wr_data = wdata_q;
  assign reg_if.rd_addr = ptr_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged controller on an open-drain SDA model.
module tb_i2c_target_regfile;
  import i2c_pkg::*;

  localparam int NREGS    = 16;
  localparam int PTR_W    = 4;
  localparam int FILT_LEN = 3;
  localparam int Q        = 6;   // quarter SCL period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic sda_ctrl = 1'b1;
  logic sda_oe, busy, addr_hit;
  logic sda_line;
  logic [7:0] mem [NREGS];

  assign sda_line = sda_ctrl & ~sda_oe;

  i2c_target_regfile_if #(.PTR_W(PTR_W)) rif ();
  assign rif.rd_data = mem[rif.rd_addr];

  i2c_target_regfile #(
    .DEV_ADDR(7'h54), .NREGS(NREGS), .PTR_W(PTR_W), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .busy(busy), .addr_hit(addr_hit), .reg_if(rif)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [PTR_W-1:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_exp [$];
  logic [7:0] rd_exp [$];
  int errors = 0;
  int checks = 0;
  int hits = 0;
  int oe_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every wait goes through here so write strobes are scored as they happen.
  task automatic tick(input int n);
    wr_t e;
    repeat (n) begin
      @(negedge clk);
      if (addr_hit) hits++;
      if (sda_oe) oe_cnt++;
      if (rif.wr_en) begin
        chk("wr_pending", 32'(wr_exp.size() != 0), 32'd1);
        if (wr_exp.size() != 0) begin
          e = wr_exp.pop_front();
          chk("wr_addr", 32'(rif.wr_addr), 32'(e.a));
          chk("wr_data", 32'(rif.wr_data), 32'(e.d));
        end
      end
    end
  endtask

  task automatic bit_xfer(input logic b, input logic glitch, output logic s);
    sda_ctrl = b;
    tick(Q);
    if (glitch) begin
      scl = 1'b1; tick(FILT_LEN - 1);
      scl = 1'b0; tick(Q);
    end
    scl = 1'b1; tick(Q);
    s = sda_line;
    tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; tick(Q);
    scl = 1'b1;      tick(2 * Q);
    sda_ctrl = 1'b0; tick(2 * Q);
    scl = 1'b0;      tick(Q);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; tick(Q);
    scl = 1'b1;      tick(2 * Q);
    sda_ctrl = 1'b1; tick(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], i == glitch_bit, s);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic ack_bit, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, s);
      b[i] = s;
    end
    bit_xfer(ack_bit, 1'b0, s);
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = PTR_W'(a);
    e.d = d;
    wr_exp.push_back(e);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    int         h0, o0;

    for (int i = 0; i < NREGS; i++) mem[i] = 8'h00;
    mem[5] = 8'h5A;
    mem[6] = 8'hC3;

    // Reset state
    tick(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_en", rif.wr_en, 0);
    chk("rst_addr_hit", addr_hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", rif.wr_addr, 0);
    chk("rst_wr_data", rif.wr_data, 0);
    chk("rst_rd_addr", rif.rd_addr, 0);
    rst_n = 1'b1;
    tick(10);

    // Burst write at pointer 3
    h0 = hits;
    i2c_start();
    wr_byte(8'hA8, -1, ack); chk("t1_hdr_ack", ack, ACK);
    chk("t1_busy", busy, 1);
    wr_byte(8'h03, -1, ack); chk("t1_ptr_ack", ack, ACK);
    exp_wr(3, 8'h11);
    wr_byte(8'h11, -1, ack); chk("t1_d0_ack", ack, ACK);
    exp_wr(4, 8'h22);
    wr_byte(8'h22, -1, ack); chk("t1_d1_ack", ack, ACK);
    chk("t1_wr_drained", wr_exp.size(), 0);
    i2c_stop();
    chk("t1_busy_stop", busy, 0);
    chk("t1_hits", hits - h0, 1);

    // Pointer wrap from 15 to 0
    i2c_start();
    wr_byte(8'hA8, -1, ack);
    wr_byte(8'h0F, -1, ack); chk("t2_ptr_ack", ack, ACK);
    exp_wr(15, 8'hAA);
    wr_byte(8'hAA, -1, ack); chk("t2_d0_ack", ack, ACK);
    exp_wr(0, 8'hBB);
    wr_byte(8'hBB, -1, ack); chk("t2_d1_ack", ack, ACK);
    chk("t2_wr_drained", wr_exp.size(), 0);
    i2c_stop();

    // Pointer write, repeated START, two-byte read
    h0 = hits;
    i2c_start();
    wr_byte(8'hA8, -1, ack);
    wr_byte(8'h05, -1, ack); chk("t3_ptr_ack", ack, ACK);
    i2c_start();
    wr_byte(8'hA9, -1, ack); chk("t3_rhdr_ack", ack, ACK);
    chk("t3_hits", hits - h0, 2);
    rd_exp.push_back(8'h5A);
    rd_exp.push_back(8'hC3);
    rd_byte(ACK, b);  chk("t3_rd0", b, rd_exp.pop_front());
    rd_byte(NACK, b); chk("t3_rd1", b, rd_exp.pop_front());
    tick(Q);
    chk("t3_released", sda_oe, 0);
    chk("t3_rd_addr", rif.rd_addr, 7);
    chk("t3_busy_pre_stop", busy, 1);
    i2c_stop();
    chk("t3_busy_stop", busy, 0);

    // Address mismatch: NACK, target stays off the bus
    h0 = hits;
    o0 = oe_cnt;
    i2c_start();
    wr_byte(8'hB0, -1, ack); chk("t4_hdr_nack", ack, NACK);
    wr_byte(8'h00, -1, ack); chk("t4_data_nack", ack, NACK);
    i2c_stop();
    chk("t4_no_oe", oe_cnt - o0, 0);
    chk("t4_no_hit", hits - h0, 0);
    chk("t4_busy", busy, 0);

    // Short SCL glitch inside a data byte
    i2c_start();
    wr_byte(8'hA8, -1, ack);
    wr_byte(8'h07, -1, ack);
    exp_wr(7, 8'h3C);
    wr_byte(8'h3C, 4, ack); chk("t5_glitch_ack", ack, ACK);
    chk("t5_wr_drained", wr_exp.size(), 0);
    i2c_stop();

    // Asynchronous reset while the target is driving a 0 in a read
    i2c_start();
    wr_byte(8'hA8, -1, ack);
    wr_byte(8'h09, -1, ack);
    i2c_start();
    wr_byte(8'hA9, -1, ack); chk("t6_rhdr_ack", ack, ACK);
    sda_ctrl = 1'b1; tick(Q);
    scl = 1'b1;      tick(Q);
    chk("t6_oe_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_oe_async", sda_oe, 0);
    chk("t6_busy_rst", busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(Q);
    scl = 1'b0; tick(Q);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA8, -1, ack); chk("t6_post_hdr_ack", ack, ACK);
    wr_byte(8'h02, -1, ack); chk("t6_post_ptr_ack", ack, ACK);
    exp_wr(2, 8'h77);
    wr_byte(8'h77, -1, ack); chk("t6_post_d_ack", ack, ACK);
    i2c_stop();

    chk("final_wr_queue", wr_exp.size(), 0);
    chk("final_rd_queue", rd_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Parametrised I2C target (slave) that oversamples SCL/SDA on a system clock. It filters the bus, detects START/repeated START/STOP, matches a 7-bit device address and then runs burst register writes and reads through a pointer that auto-increments and wraps. It is the successor to the SCL-clocked `slave_sda_generate`: it adds a register pointer, multi-byte bursts, NACK on a non-matching address and a host-side register port. It sits between the board-level open-drain pads and the local register bank.

## Interface
- `DEV_ADDR`, default 7'h54: 7-bit device address. The write header is 8'hA8 and the read header is 8'hA9.
- `NREGS`, default 16: number of registers; must be ≥ 2.
- `PTR_W`, default $clog2(NREGS): pointer width.
- `FILT_LEN`, default 3: glitch-filter length in clk cycles.
- `clk` in 1: system clock; must be ≥ 10× the SCL rate.
- `rst_n` in 1: asynchronous, active-low reset.
- `scl_in` in 1: SCL pad input, asynchronous.
- `sda_in` in 1: SDA pad input, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low. The pad drives 0 when asserted and is high-Z otherwise.
- `wr_en` out 1: one-clk pulse that commits one written byte.
- `wr_addr` out PTR_W: register index for `wr_en`.
- `wr_data` out 8: byte for `wr_en`.
- `rd_addr` out PTR_W: current read index. Valid continuously.
- `rd_data` in 8: register contents at `rd_addr`. Combinational from the host side.
- `busy` out 1: high from an address match until STOP.
- `addr_hit` out 1: one-clk pulse when the address byte matches.

## Operation
- Input conditioning:
  - Two-flop synchroniser on each line.
  - A line's filtered value changes only after FILT_LEN consecutive equal samples.
  - Edges are detected on the filtered values only.
- Bus events:
  - START: filtered SDA falls while filtered SCL is high. It is also a repeated START when it occurs in any state.
  - STOP: filtered SDA rises while filtered SCL is high.
  - STOP has priority: it returns the FSM to IDLE from any state.
- Bit timing:
  - Data bits are sampled MSB first on each filtered SCL rising edge.
  - `sda_oe` changes only on filtered SCL falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
  - IDLE→ADDR on START. Any START in any state → ADDR with the bit counter cleared.
  - ADDR: shift 8 bits.
    - On match, pulse `addr_hit`, set `busy`, go to ADDR_ACK and drive ACK for one SCL period.
    - On mismatch, go to IDLE and leave `sda_oe` = 0 (NACK).
  - ADDR_ACK exit:
    - R/W = 0 → PTR.
    - R/W = 1 → RDATA, loading the shift register from `rd_data` at `rd_addr` = pointer.
  - PTR: the received byte mod NREGS is loaded into the pointer. ACK, then → WDATA.
  - WDATA: after 8 bits, on the 8th rising edge:
    - pulse `wr_en`, with `wr_addr` = pointer and `wr_data` = byte;
    - pointer increments;
    - ACK, then → WDATA.
  - RDATA:
    - Drive bits: `sda_oe` = ~bit.
    - After the 8th bit, release SDA, increment the pointer and go to RACK.
  - RACK: sample the controller's ack bit.
    - ACK (0) → RDATA, with the next byte loaded on the falling edge.
    - NACK (1) → IDLE, SDA released.
- Pointer:
  - Wraps from NREGS-1 to 0.
  - It is retained across repeated START, so write-pointer-then-Sr-read works.
  - It is also retained across STOP.
- Reset outputs:
  - `sda_oe` = 0, `wr_en` = 0, `addr_hit` = 0, `busy` = 0.
  - `wr_addr`, `wr_data` and `rd_addr` = 0.
  - Pointer = 0, FSM = IDLE.
- Reset mid-transfer: SDA is released immediately, since the reset is asynchronous. After reset the block ignores the bus until the next START.

## Timing
- Pad-to-filtered-value latency: 2 + FILT_LEN clk.
- `wr_en` asserts 1 clk after the 8th filtered SCL rising edge of a data byte.
- `addr_hit` asserts 1 clk after the 8th filtered SCL rising edge of the address byte.
- `sda_oe`:
  - asserts/deasserts 1 clk after the filtered SCL falling edge;
  - the ACK window spans exactly one SCL low-high-low period.
- `rd_data` is sampled 1 clk after a filtered SCL falling edge, so the host must return data within 1 clk of `rd_addr` changing.
- START and STOP while SCL is high are never misread as data, because data is sampled only on SCL rising edges.

## Structure
- Shared package `i2c_pkg`:
  - FSM state enum;
  - constants ACK = 1'b0 and NACK = 1'b1;
  - header-bit positions.
- Sub-module `i2c_line_filter`: synchroniser + glitch filter + rise/fall strobes. Instantiated twice, once per line.

## Test plan
- Write 8'hA8, pointer 8'h03, data 8'h11, 8'h22, STOP → `wr_en` fires twice: (3, 8'h11) then (4, 8'h22). ACK is seen on all 4 bytes.
- Write 8'hA8, pointer 8'h0F, bytes 8'hAA, 8'hBB → writes go to 15 then 0 (pointer wrap).
- Write 8'hA8, pointer 8'h05, Sr, 8'hA9, host returns `rd_data` = 8'h5A for index 5 and 8'hC3 for index 6, controller ACKs then NACKs → SDA carries 8'h5A then 8'hC3, then is released. `busy` falls on STOP.
- Header 8'hB0 (address mismatch) → NACK, no `addr_hit`, `sda_oe` stays 0 until the next START.
- Glitch of FILT_LEN-1 clk on SCL during a data bit → no extra bit is shifted and the received byte is unchanged.
- `rst_n` asserted while the block is driving a read 0 → `sda_oe` = 0 immediately. After release, the next 8'hA8 transaction succeeds.
